block_reader: RTL and testbench

- Reads back a square block of pixels from the game's shadow frame memory: 160x120 pixels, 3-bit colour, synchronous read port with 1-cycle latency.
- Compares every pixel in the block against a target colour and reports the match count and summary flags.
- It is the read-side counterpart of the block-drawing path. The tap/collision logic uses it to check whether a block region is already occupied before drawing, or to confirm that a draw landed.

---
 rtl/block_reader_if.sv | 25 ++
 rtl/block_reader.sv | 91 +++++++++
 tb/tb_block_reader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_reader_if.sv
// block_reader_if: request, frame-memory read port and result signals of the block reader.
interface block_reader_if;
    logic       start;
    logic [7:0] start_x;
    logic [6:0] start_y;
    logic [3:0] block_size;
    logic [2:0] target_colour;
    logic [7:0] mem_x;
    logic [6:0] mem_y;
    logic       mem_rd;
    logic [2:0] mem_colour;
    logic       busy;
    logic       done;
    logic [7:0] match_count;
    logic       any_match;
    logic       all_match;
    modport master (
        output start, start_x, start_y, block_size, target_colour, mem_colour,
        input  mem_x, mem_y, mem_rd, busy, done, match_count, any_match, all_match
    );
    modport slave (
        input  start, start_x, start_y, block_size, target_colour, mem_colour,
        output mem_x, mem_y, mem_rd, busy, done, match_count, any_match, all_match
    );
endinterface

// File: rtl/block_reader.sv
// block_reader: scans a square block of the shadow frame memory and counts pixels equal to a target colour.
module block_reader #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic clock,
    input logic reset,
    block_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam logic [7:0] MAX_X = 8'(SCREEN_W);
    localparam logic [6:0] MAX_Y = 7'(SCREEN_H);
    state_t     state, state_n;
    logic [7:0] sx, mem_x_n, count, size_sq;
    logic [6:0] sy, mem_y_n;
    logic [3:0] sz, ox, oy, ox_n, oy_n;
    logic [2:0] tc;
    logic       load, issue, last, vld;
    always_comb begin
        state_n = state;
        ox_n    = ox;
        oy_n    = oy;
        load    = 1'b0;
        issue   = 1'b0;
        last    = ox == sz - 4'd1 && oy == sz - 4'd1;
        case (state)
            IDLE: if (bus.start) begin
                load    = 1'b1;
                issue   = bus.block_size != 4'd0;
                state_n = issue ? READ : DONE;
                ox_n    = 4'd0;
                oy_n    = 4'd0;
            end
            READ: if (last) begin
                state_n = DRAIN;
            end else begin
                issue = 1'b1;
                ox_n  = ox == sz - 4'd1 ? 4'd0 : ox + 4'd1;
                oy_n  = ox == sz - 4'd1 ? oy + 4'd1 : oy;
            end
            DRAIN:   state_n = DONE;
            default: state_n = IDLE;
        endcase
        // address of the pixel issued next; sums wrap like the draw path
        mem_x_n = (load ? bus.start_x : sx) + {4'd0, ox_n};
        mem_y_n = (load ? bus.start_y : sy) + {3'd0, oy_n};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sx         <= '0;
            sy         <= '0;
            sz         <= '0;
            tc         <= '0;
            ox         <= '0;
            oy         <= '0;
            bus.mem_x  <= '0;
            bus.mem_y  <= '0;
            bus.mem_rd <= 1'b0;
            vld        <= 1'b0;
            count      <= '0;
        end else begin
            state <= state_n;
            ox    <= ox_n;
            oy    <= oy_n;
            if (load) begin
                sx <= bus.start_x;
                sy <= bus.start_y;
                sz <= bus.block_size;
                tc <= bus.target_colour;
            end
            if (issue) begin
                bus.mem_x <= mem_x_n;
                bus.mem_y <= mem_y_n;
            end
            // off-screen pixels still take their cycle but never strobe the memory
            bus.mem_rd <= issue && mem_x_n < MAX_X && mem_y_n < MAX_Y;
            vld        <= bus.mem_rd;
            if (load)
                count <= '0;
            else if (vld && bus.mem_colour == tc)
                count <= count + 8'd1;
        end
    end
    assign size_sq         = {4'd0, sz} * {4'd0, sz};
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.match_count = count;
    assign bus.any_match   = count != 8'd0;
    assign bus.all_match   = sz != 4'd0 && count == size_sq;
endmodule

// File: tb/tb_block_reader.sv
// tb_block_reader: randomized and directed scans checked against a pixel-level model of the block reader.
module tb_block_reader;
    typedef struct packed {int c; logic [7:0] x; logic [6:0] y;} rd_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int cyc = 0, vectors = 0, miscompares = 0, busy_n = 0;
    rd_t rd_q[$], exp_q[$];
    int done_q[$];
    logic [9:0] res_q[$];
    logic [2:0] mem [256][128];
    logic [2:0] rdata = 3'd0;

    block_reader_if bus();
    block_reader dut (.clock(clock), .reset(reset), .bus(bus.slave));

    assign bus.mem_colour = rdata;
    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // garbage on the data bus whenever no read was strobed
    always @(posedge clock) rdata <= bus.mem_rd ? mem[bus.mem_x][bus.mem_y] : 3'($urandom);
    // cycle numbering: the cycle ending at edge n is cycle n
    always @(negedge clock) begin
        if (bus.mem_rd) rd_q.push_back({cyc + 1, bus.mem_x, bus.mem_y});
        if (bus.busy) busy_n++;
        if (bus.done) begin
            done_q.push_back(cyc + 1);
            res_q.push_back({bus.match_count, bus.any_match, bus.all_match});
        end
    end

    task automatic fill(input logic [2:0] c);
        for (int x = 0; x < 256; x++) for (int y = 0; y < 128; y++) mem[x][y] = c;
    endtask

    task automatic fill_rect(input int x0, input int y0, input int w, input int h, input logic [2:0] c);
        for (int x = x0; x < x0 + w; x++) for (int y = y0; y < y0 + h; y++) mem[x][y] = c;
    endtask

    task automatic fill_rand(input int ncol);
        for (int x = 0; x < 256; x++) for (int y = 0; y < 128; y++) mem[x][y] = 3'($urandom_range(ncol - 1, 0));
    endtask

    // every pixel of the block in row-major order, one per cycle; only visible ones are read
    task automatic model(input logic [7:0] sx, input logic [6:0] sy, input int sz, input logic [2:0] tc,
                         input int k, output logic [9:0] res);
        int cnt = 0;
        for (int oy = 0; oy < sz; oy++) for (int ox = 0; ox < sz; ox++) begin
            logic [7:0] x;
            logic [6:0] y;
            x = 8'((int'(sx) + ox) % 256);
            y = 7'((int'(sy) + oy) % 128);
            if (x < 160 && y < 120) begin
                exp_q.push_back({k + 1 + oy * sz + ox, x, y});
                if (mem[x][y] == tc) cnt++;
            end
        end
        res = {8'(cnt), cnt != 0, cnt == sz * sz && sz != 0};
    endtask

    task automatic kick(input logic [7:0] sx, input logic [6:0] sy, input logic [3:0] sz,
                        input logic [2:0] tc, output int k);
        @(negedge clock);
        rd_q.delete(); exp_q.delete(); done_q.delete(); res_q.delete(); busy_n = 0;
        bus.start = 1'b1; bus.start_x = sx; bus.start_y = sy; bus.block_size = sz; bus.target_colour = tc;
        k = cyc + 1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.start_x = 8'($urandom); bus.start_y = 7'($urandom);
        bus.block_size = 4'($urandom); bus.target_colour = 3'($urandom);
    endtask

    task automatic wait_done(input int n, input string name);
        for (int i = 0; i < 300 && done_q.size() < n; i++) @(negedge clock);
        if (done_q.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: %0d done pulses, required %0d", name, done_q.size(), n);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({bus.mem_x, bus.mem_y, bus.mem_rd, bus.busy, bus.done, bus.match_count, bus.any_match, bus.all_match} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset outputs: got x%0d y%0d rd%b busy%b done%b cnt%0d, required all zero",
                     bus.mem_x, bus.mem_y, bus.mem_rd, bus.busy, bus.done, bus.match_count);
        end
        reset = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_no_match();
        int k; logic [9:0] er; bit bad;
        fill(3'b000);
        kick(8'd10, 7'd20, 4'd4, 3'b100, k);
        model(8'd10, 7'd20, 4, 3'b100, k, er);
        wait_done(1, "no_match");
        vectors++; bad = rd_q.size() != exp_q.size() || exp_q.size() != 16;
        foreach (exp_q[i]) if (!bad && rd_q[i] !== exp_q[i]) bad = 1;
        if (bad) begin miscompares++; $display("FAIL no_match reads: got %0d reads, required 16 in row-major order", rd_q.size()); end
        vectors++;
        if (done_q.size() < 1 || done_q[0] != k + 18) begin
            miscompares++; $display("FAIL no_match done cycle: got %0d, required %0d", done_q.size() ? done_q[0] - k : -1, 18);
        end
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== 10'd0) begin
            miscompares++; $display("FAIL no_match result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, 10'd0);
        end
    endtask

    task automatic test_full_match();
        int k; logic [9:0] er;
        fill(3'b000); fill_rect(10, 20, 4, 4, 3'b100);
        kick(8'd10, 7'd20, 4'd4, 3'b100, k);
        wait_done(1, "full_match");
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== {8'd16, 1'b1, 1'b1}) begin
            miscompares++; $display("FAIL full_match result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, {8'd16, 2'b11});
        end
        vectors++;
        if ({bus.match_count, bus.any_match, bus.all_match} !== {8'd16, 1'b1, 1'b1}) begin
            miscompares++; $display("FAIL full_match hold: got cnt %0d, required 16", bus.match_count);
        end
        kick(8'd12, 7'd22, 4'd4, 3'b100, k);
        model(8'd12, 7'd22, 4, 3'b100, k, er);
        wait_done(1, "partial_match");
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== {8'd4, 1'b1, 1'b0} || er !== {8'd4, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL partial_match result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, {8'd4, 2'b10});
        end
        vectors++;
        if (done_q.size() < 1 || done_q[0] != k + 18) begin
            miscompares++; $display("FAIL partial_match done cycle: got %0d, required 18", done_q.size() ? done_q[0] - k : -1);
        end
    endtask

    task automatic test_edge_clip();
        int k; logic [9:0] er; bit bad;
        fill(3'b100);
        kick(8'd158, 7'd118, 4'd3, 3'b100, k);
        model(8'd158, 7'd118, 3, 3'b100, k, er);
        wait_done(1, "edge_clip");
        vectors++; bad = rd_q.size() != exp_q.size() || exp_q.size() != 4;
        foreach (exp_q[i]) if (!bad && rd_q[i] !== exp_q[i]) bad = 1;
        if (bad) begin miscompares++; $display("FAIL edge_clip reads: got %0d reads, required 4 visible pixels", rd_q.size()); end
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== {8'd4, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL edge_clip result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, {8'd4, 2'b10});
        end
        vectors++;
        if (done_q.size() < 1 || done_q[0] != k + 11) begin
            miscompares++; $display("FAIL edge_clip done cycle: got %0d, required 11", done_q.size() ? done_q[0] - k : -1);
        end
    endtask

    task automatic test_size_zero();
        int k;
        fill(3'b010);
        kick(8'd30, 7'd40, 4'd0, 3'b010, k);
        wait_done(1, "size_zero");
        vectors++;
        if (done_q.size() != 1 || done_q[0] != k + 1) begin
            miscompares++; $display("FAIL size_zero done: got %0d pulses at %0d, required 1 at 1", done_q.size(), done_q.size() ? done_q[0] - k : -1);
        end
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== 10'd0) begin
            miscompares++; $display("FAIL size_zero result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, 10'd0);
        end
        vectors++;
        if (rd_q.size() != 0) begin miscompares++; $display("FAIL size_zero reads: got %0d, required 0", rd_q.size()); end
    endtask

    task automatic test_reset_abort();
        int k; logic [9:0] er; bit bad;
        fill_rand(2);
        kick(8'd20, 7'd30, 4'd15, 3'd1, k);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if ({bus.mem_x, bus.mem_y, bus.mem_rd, bus.busy, bus.done, bus.match_count, bus.any_match, bus.all_match} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_abort outputs: got x%0d y%0d rd%b busy%b cnt%0d, required all zero",
                     bus.mem_x, bus.mem_y, bus.mem_rd, bus.busy, bus.match_count);
        end
        reset = 1'b0;
        kick(8'd100, 7'd50, 4'd2, mem[100][50], k);
        model(8'd100, 7'd50, 2, mem[100][50], k, er);
        wait_done(1, "after_abort");
        vectors++; bad = rd_q.size() != exp_q.size();
        foreach (exp_q[i]) if (!bad && rd_q[i] !== exp_q[i]) bad = 1;
        if (bad) begin miscompares++; $display("FAIL after_abort reads: got %0d reads, required %0d", rd_q.size(), exp_q.size()); end
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== er) begin
            miscompares++; $display("FAIL after_abort result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, er);
        end
        vectors++;
        if (done_q.size() < 1 || done_q[0] != k + 6) begin
            miscompares++; $display("FAIL after_abort done cycle: got %0d, required 6", done_q.size() ? done_q[0] - k : -1);
        end
    endtask

    task automatic test_start_ignored();
        int k; logic [9:0] er; bit bad;
        fill_rand(2);
        kick(8'd5, 7'd5, 4'd15, 3'd0, k);
        model(8'd5, 7'd5, 15, 3'd0, k, er);
        // poke start during READ, DRAIN and DONE with unrelated parameters
        while (cyc + 1 < k + 229) begin
            bus.start = cyc + 1 == k + 3 || cyc + 1 == k + 100 || cyc + 1 == k + 226 || cyc + 1 == k + 227;
            bus.block_size = 4'd3; bus.start_x = 8'($urandom); bus.target_colour = 3'd1;
            @(negedge clock);
        end
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        vectors++;
        if (done_q.size() != 1 || done_q[0] != k + 227) begin
            miscompares++; $display("FAIL start_ignored done: got %0d pulses, first at %0d, required 1 at 227", done_q.size(), done_q.size() ? done_q[0] - k : -1);
        end
        vectors++;
        if (res_q.size() < 1 || res_q[0] !== er) begin
            miscompares++; $display("FAIL start_ignored result: got %b, required %b", res_q.size() ? res_q[0] : 10'bx, er);
        end
        vectors++; bad = rd_q.size() != exp_q.size() || bus.busy !== 1'b0;
        foreach (exp_q[i]) if (!bad && rd_q[i] !== exp_q[i]) bad = 1;
        if (bad) begin miscompares++; $display("FAIL start_ignored reads: got %0d reads busy %b, required %0d idle", rd_q.size(), bus.busy, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int k; logic [9:0] er; bit bad;
        fill_rand(2);
        @(negedge clock);
        rd_q.delete(); exp_q.delete(); done_q.delete(); res_q.delete();
        bus.start = 1'b1; bus.start_x = 8'd40; bus.start_y = 7'd60; bus.block_size = 4'd2; bus.target_colour = 3'd1;
        k = cyc + 1;
        model(8'd40, 7'd60, 2, 3'd1, k, er);
        model(8'd40, 7'd60, 2, 3'd1, k + 7, er);
        while (done_q.size() == 0 && cyc < k + 20) @(negedge clock);
        repeat (2) @(negedge clock);
        bus.start = 1'b0;
        wait_done(2, "back_to_back");
        vectors++;
        if (done_q.size() != 2 || done_q[0] != k + 6 || done_q[1] != k + 13) begin
            miscompares++; $display("FAIL back_to_back done: got %0d pulses, first at %0d, required 2 at 6 and 13", done_q.size(), done_q.size() ? done_q[0] - k : -1);
        end
        vectors++; bad = rd_q.size() != exp_q.size();
        foreach (exp_q[i]) if (!bad && rd_q[i] !== exp_q[i]) bad = 1;
        if (bad) begin miscompares++; $display("FAIL back_to_back reads: got %0d reads, required %0d", rd_q.size(), exp_q.size()); end
        vectors++;
        if (rd_q.size() < 5 || rd_q[4].c != k + 8) begin
            miscompares++; $display("FAIL back_to_back second read start: got %0d, required 8", rd_q.size() > 4 ? rd_q[4].c - k : -1);
        end
        vectors++;
        if (res_q.size() != 2 || res_q[0] !== er || res_q[1] !== er) begin
            miscompares++; $display("FAIL back_to_back result: got %0d results, required two of %b", res_q.size(), er);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int k, ndone, nbusy; logic [9:0] er; bit bad;
            logic [7:0] sx; logic [6:0] sy; logic [3:0] sz; logic [2:0] tc;
            fill_rand(it % 3 == 0 ? 1 : (it % 3 == 1 ? 2 : 8));
            sx = it % 4 == 0 ? 8'($urandom_range(255, 145)) : 8'($urandom);
            sy = it % 4 == 1 ? 7'($urandom_range(127, 105)) : 7'($urandom);
            sz = 4'($urandom_range(15, 0));
            tc = 3'($urandom_range(1, 0));
            kick(sx, sy, sz, tc, k);
            model(sx, sy, int'(sz), tc, k, er);
            wait_done(1, "random");
            ndone = sz == 0 ? 1 : int'(sz) * int'(sz) + 2;
            nbusy = sz == 0 ? 1 : int'(sz) * int'(sz) + 2;
            vectors++; bad = rd_q.size() != exp_q.size();
            foreach (exp_q[i]) if (!bad && rd_q[i] !== exp_q[i]) bad = 1;
            if (bad) begin miscompares++; $display("FAIL random %0d reads (%0d,%0d,%0d): got %0d reads, required %0d", it, sx, sy, sz, rd_q.size(), exp_q.size()); end
            vectors++;
            if (done_q.size() != 1 || done_q[0] != k + ndone) begin
                miscompares++; $display("FAIL random %0d done cycle: got %0d, required %0d", it, done_q.size() ? done_q[0] - k : -1, ndone);
            end
            vectors++;
            if (res_q.size() < 1 || res_q[0] !== er) begin
                miscompares++; $display("FAIL random %0d result: got %b, required %b", it, res_q.size() ? res_q[0] : 10'bx, er);
            end
            vectors++;
            if (busy_n != nbusy) begin miscompares++; $display("FAIL random %0d busy cycles: got %0d, required %0d", it, busy_n, nbusy); end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.start_x = '0; bus.start_y = '0; bus.block_size = '0; bus.target_colour = '0;
        fill(3'b000);
        test_reset();
        test_no_match();
        test_full_match();
        test_edge_clip();
        test_size_zero();
        test_reset_abort();
        test_start_ignored();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
